// File: rtl/traffic_pkg.sv
// Shared types and default interval lengths for the traffic controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED    = 3'b001,
    YELLOW = 3'b010,
    GREEN  = 3'b100
  } lights_e;

  typedef enum logic [3:0] {
    LIGHT_1 = 4'b0001,
    LIGHT_2 = 4'b0010,
    LIGHT_3 = 4'b0100,
    LIGHT_4 = 4'b1000
  } state_e;

  localparam int DEFAULT_SHORT_S  = 10;
  localparam int DEFAULT_LONG_S   = 60;
  localparam int DEFAULT_YELLOW_S = 3;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-CLK_HZ counter; tick marks the last cycle of each second.
module tick_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (en)  cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_timer.sv
// Per-phase seconds timer with done pulse and four-approach lamp driver.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SHORT_S  = DEFAULT_SHORT_S,
  parameter int LONG_S   = DEFAULT_LONG_S,
  parameter int YELLOW_S = DEFAULT_YELLOW_S
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] current_state,
  input  logic       short_counter,
  input  logic       long_counter,
  output logic       counter_done,
  output logic [6:0] remaining_s,
  output logic [2:0] o_light_1,
  output logic [2:0] o_light_2,
  output logic [2:0] o_light_3,
  output logic [2:0] o_light_4
);

  localparam logic [6:0] SHORT_L  = 7'(SHORT_S);
  localparam logic [6:0] LONG_L   = 7'(LONG_S);
  localparam logic [6:0] YELLOW_L = 7'(YELLOW_S);

  logic [3:0] prev_q;
  logic       first_q;
  logic       running_q, running_d;
  logic [6:0] rem_q, rem_d;
  logic       valid, entry, tick;
  logic [3:0] lit;
  lights_e    lamp_on;

  assign valid = $onehot(current_state);
  assign entry = first_q || (current_state != prev_q);

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (running_q),
    .clr   (entry || !valid),
    .tick  (tick)
  );

  // Reload on entry outranks a coinciding final tick, so the aborted count never pulses.
  always_comb begin
    running_d = running_q;
    rem_d     = rem_q;
    if (!valid) begin
      running_d = 1'b0;
      rem_d     = '0;
    end else if (entry) begin
      if (long_counter) begin
        running_d = 1'b1;
        rem_d     = LONG_L;
      end else if (short_counter) begin
        running_d = 1'b1;
        rem_d     = SHORT_L;
      end else begin
        running_d = 1'b0;
        rem_d     = '0;
      end
    end else if (tick) begin
      rem_d = rem_q - 7'd1;
      if (rem_q == 7'd1) running_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 4'b0001;
      first_q   <= 1'b1;
      running_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      prev_q    <= current_state;
      first_q   <= 1'b0;
      running_q <= running_d;
      rem_q     <= rem_d;
    end
  end

  // Pulse coincides with the expiring tick so the upstream FSM advances on that same edge.
  assign counter_done = valid && !entry && tick && (rem_q == 7'd1);
  assign remaining_s  = rem_q;

  assign lit     = (valid && running_q) ? current_state : 4'b0000;
  assign lamp_on = (rem_q > YELLOW_L) ? GREEN : YELLOW;

  assign o_light_1 = lit[0] ? lamp_on : RED;
  assign o_light_2 = lit[1] ? lamp_on : RED;
  assign o_light_3 = lit[2] ? lamp_on : RED;
  assign o_light_4 = lit[3] ? lamp_on : RED;

endmodule
